// File: rtl/psx_pkg.sv
// Shared state encoding, PSX protocol byte values and frame packing helper
// for the PSX host poller.
package psx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SHIFT,
    ST_WAIT_ACK,
    ST_GAP,
    ST_RELEASE
  } psx_state_e;

  localparam logic [7:0] PSX_CMD_ADDR   = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
  localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
  localparam logic [7:0] PSX_PAD_MARK   = 8'h5A;

  // Frames are packed little-endian: byte idx occupies [8*idx+7:8*idx].
  function automatic int psx_byte_lsb(input int idx);
    return 8 * idx;
  endfunction

endpackage

// File: rtl/psx_bit_shifter.sv
// One-byte PSX bus shifter: drives psx_clk/cmd LSB first and captures data
// on the first cycle of each high phase; byte_done_o marks the byte's last cycle.
module psx_bit_shifter #(
  parameter int HALF_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       data_i,
  output logic       psx_clk_o,
  output logic       cmd_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o
);

  localparam int HW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;

  logic          active_q;
  logic          psx_clk_q;
  logic          cmd_q;
  logic [HW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    tx_q;
  logic [7:0]    rx_q;
  logic [7:0]    rx_d;
  logic          phase_end;
  logic          sample_en;

  assign phase_end   = (cnt_q == HW'(HALF_BIT - 1));
  assign sample_en   = active_q && psx_clk_q && (cnt_q == '0);
  assign byte_done_o = active_q && psx_clk_q && phase_end && (bit_q == 3'd7);

  // rx_byte_o exposes the next value so bit 7 is included even when HALF_BIT=1.
  always_comb begin
    rx_d = rx_q;
    if (sample_en) rx_d[bit_q] = data_i;
  end

  assign rx_byte_o = rx_d;
  assign psx_clk_o = psx_clk_q;
  assign cmd_o     = cmd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= 1'b0;
      psx_clk_q <= 1'b1;
      cmd_q     <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
    end else begin
      rx_q <= rx_d;
      if (start_i) begin
        active_q  <= 1'b1;
        psx_clk_q <= 1'b0;
        cmd_q     <= tx_byte_i[0];
        cnt_q     <= '0;
        bit_q     <= '0;
        tx_q      <= tx_byte_i;
        rx_q      <= '0;
      end else if (active_q) begin
        if (!phase_end) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          cnt_q <= '0;
          if (!psx_clk_q) begin
            psx_clk_q <= 1'b1;
          end else if (bit_q == 3'd7) begin
            active_q <= 1'b0;
            cmd_q    <= 1'b1;
          end else begin
            psx_clk_q <= 1'b0;
            bit_q     <= bit_q + 3'd1;
            cmd_q     <= tx_q[bit_q + 3'd1];
          end
        end
      end
    end
  end

endmodule

// File: rtl/psx_host_poller.sv
// PSX controller bus host: selects a port, shifts a command frame out and the
// reply in, paced by ack. Define PSX_ACK_TIMEOUT_EN to abort on a missing ack.
module psx_host_poller
  import psx_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int MAX_BYTES   = 9,
  parameter int HALF_BIT    = 2,
  parameter int BYTE_GAP    = 4,
  parameter int ACK_TIMEOUT = 64,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CW = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PW-1:0]          port_sel,
  input  logic [CW-1:0]          num_bytes,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  output logic [8*MAX_BYTES-1:0] rx_data,
  output logic [CW-1:0]          rx_count,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout,
  output logic [NUM_PORTS-1:0]   att,
  output logic                   psx_clk,
  output logic                   cmd,
  input  logic                   data,
  input  logic                   ack
);

  localparam int GW = $clog2(BYTE_GAP + 1);

  psx_state_e             state_q;
  logic [NUM_PORTS-1:0]   att_q;
  logic [8*MAX_BYTES-1:0] tx_q;
  logic [8*MAX_BYTES-1:0] rx_data_q;
  logic [CW-1:0]          nbytes_q;
  logic [CW-1:0]          rx_count_q;
  logic [CW-1:0]          nbytes_clamped;
  logic                   busy_q;
  logic                   done_q;
  logic [GW-1:0]          gap_q;
  logic                   gap_end;
  logic                   shift_start;
  logic                   byte_done;
  logic [7:0]             tx_byte;
  logic [7:0]             rx_byte;

`ifdef PSX_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_q;
  logic          err_q;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign nbytes_clamped = (num_bytes > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : num_bytes;
  assign gap_end        = (gap_q == GW'(BYTE_GAP - 1));
  // Launch the shifter on the last gap cycle so psx_clk falls as SHIFT begins.
  assign shift_start    = ((state_q == ST_SELECT) || (state_q == ST_GAP)) && gap_end;
  assign tx_byte        = tx_q[psx_byte_lsb(int'(rx_count_q)) +: 8];

  psx_bit_shifter #(
    .HALF_BIT(HALF_BIT)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (shift_start),
    .tx_byte_i  (tx_byte),
    .data_i     (data),
    .psx_clk_o  (psx_clk),
    .cmd_o      (cmd),
    .byte_done_o(byte_done),
    .rx_byte_o  (rx_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      att_q      <= '1;
      tx_q       <= '0;
      rx_data_q  <= '0;
      nbytes_q   <= '0;
      rx_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gap_q      <= '0;
`ifdef PSX_ACK_TIMEOUT_EN
      to_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A start landing on the done cycle is dropped.
          if (start && !done_q) begin
            rx_data_q  <= '0;
            rx_count_q <= '0;
            tx_q       <= tx_data;
            nbytes_q   <= nbytes_clamped;
            gap_q      <= '0;
`ifdef PSX_ACK_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            if ((nbytes_clamped == '0) || (int'(port_sel) >= NUM_PORTS)) begin
              done_q <= 1'b1;
            end else begin
              busy_q          <= 1'b1;
              att_q[port_sel] <= 1'b0;
              state_q         <= ST_SELECT;
            end
          end
        end
        ST_SELECT, ST_GAP: begin
          if (gap_end) state_q <= ST_SHIFT;
          else         gap_q   <= gap_q + 1'b1;
        end
        ST_SHIFT: begin
          if (byte_done) begin
            rx_data_q[psx_byte_lsb(int'(rx_count_q)) +: 8] <= rx_byte;
            rx_count_q <= rx_count_q + 1'b1;
            gap_q      <= '0;
`ifdef PSX_ACK_TIMEOUT_EN
            to_q       <= '0;
`endif
            if (rx_count_q + 1'b1 == nbytes_q) state_q <= ST_RELEASE;
            else                               state_q <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (!ack) begin
            state_q <= ST_GAP;
          end
`ifdef PSX_ACK_TIMEOUT_EN
          else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
            state_q <= ST_RELEASE;
            err_q   <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
`endif
        end
        ST_RELEASE: begin
          if (gap_end) begin
            att_q   <= '1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign att      = att_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign rx_count = rx_count_q;

endmodule

// File: tb/tb_psx_host_poller.sv
// Directed bench for psx_host_poller with a behavioural controller on the bus
// and a scoreboard of expected frame results (PSX_ACK_TIMEOUT_EN optional).
module tb_psx_host_poller;
  import psx_pkg::*;

  localparam int NP = 2;
  localparam int MB = 9;
  localparam int HB = 2;
  localparam int BG = 4;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [0:0]  port_sel = '0;
  logic [3:0]  num_bytes = '0;
  logic [71:0] tx_data = '0;
  logic [71:0] rx_data;
  logic [3:0]  rx_count;
  logic        busy, done, err_timeout;
  logic [1:0]  att;
  logic        psx_clk, cmd;
  logic        data = 1'b1;
  logic        ack = 1'b1;

  always #5 clk = ~clk;

  psx_host_poller #(
    .NUM_PORTS(NP), .MAX_BYTES(MB), .HALF_BIT(HB), .BYTE_GAP(BG), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .port_sel(port_sel), .num_bytes(num_bytes),
    .tx_data(tx_data), .rx_data(rx_data), .rx_count(rx_count), .busy(busy), .done(done),
    .err_timeout(err_timeout), .att(att), .psx_clk(psx_clk), .cmd(cmd), .data(data), .ack(ack)
  );

  typedef struct {
    int          lat;
    logic [71:0] rx;
    int          cnt;
    logic        err;
    int          falls;
    logic [71:0] cmdv;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  reply   [0:8];
  logic [7:0]  cmd_cap [0:8];
  int          cur_n = 0;
  int          ack_dly = 1;
  bit          ack_en = 1'b1;
  int          bc = 0;
  int          pc = 0;

  // Controller reply: next bit presented as psx_clk falls.
  initial begin : data_model
    forever begin
      @(negedge psx_clk);
      if (bc < 72) data = reply[bc / 8][bc % 8];
      bc++;
    end
  end

  // Controller cmd capture on rising psx_clk and ack after each non-final byte.
  initial begin : ack_model
    forever begin
      @(posedge psx_clk);
      if (pc < 72) cmd_cap[pc / 8][pc % 8] = cmd;
      pc++;
      if (ack_en && (pc % 8 == 0) && (pc / 8 < cur_n)) begin
        repeat (HB + ack_dly - 1) @(posedge clk);
        #1 ack = 1'b0;
        @(posedge clk);
        #1 ack = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input int port, input int nb, input logic [71:0] tx,
                         input int a, input bit ack_on, input bit poke);
    exp_t        ex, e;
    int          n, shifted, k, falls_seen;
    bit          got, prev_clk, other_low;
    logic [1:0]  att_first, att_exp, other_mask;
    logic [71:0] mask, cmd_obs;

    n       = (nb > MB) ? MB : nb;
    shifted = ack_on ? n : ((n > 0) ? 1 : 0);
    mask    = '0;
    ex.rx   = '0;
    for (int i = 0; i < shifted; i++) begin
      mask[8*i +: 8]  = 8'hFF;
      ex.rx[8*i +: 8] = reply[i];
    end
    if (n == 0)      ex.lat = 1;
    else if (ack_on) ex.lat = 1 + BG * (n + 1) + 16 * HB * n + (n - 1) * a;
    else             ex.lat = 1 + BG + 16 * HB + TO + BG;
    ex.cnt   = shifted;
    ex.err   = !ack_on && (n > 1);
    ex.falls = 8 * shifted;
    ex.cmdv  = tx & mask;
    att_exp  = 2'b11;
    if (n > 0) att_exp[port] = 1'b0;
    other_mask       = 2'b11;
    other_mask[port] = 1'b0;

    for (int i = 0; i < 9; i++) cmd_cap[i] = 8'h00;
    bc = 0; pc = 0;
    cur_n = n; ack_dly = a; ack_en = ack_on;

    @(negedge clk);
    port_sel  = 1'(port);
    num_bytes = 4'(nb);
    tx_data   = tx;
    start     = 1'b1;
    sb.push_back(ex);
    @(negedge clk);
    start = 1'b0;

    k = 1; got = 0; prev_clk = 1'b1; other_low = 0; falls_seen = 0;
    att_first = att;
    while (!got && k <= 4000) begin
      if (prev_clk && !psx_clk) falls_seen++;
      prev_clk = psx_clk;
      if ((~att & other_mask) != 2'b00) other_low = 1;
      if (done) begin
        got = 1;
      end else begin
        if (poke && k == 40) begin
          start = 1'b1; port_sel = ~port_sel; num_bytes = 4'd2; tx_data = ~tx;
        end else if (poke && k == 41) begin
          start = 1'b0; port_sel = 1'(port); num_bytes = 4'(nb); tx_data = tx;
        end
        @(negedge clk);
        k++;
      end
    end

    e = sb.pop_front();
    for (int i = 0; i < 9; i++) cmd_obs[8*i +: 8] = cmd_cap[i];
    check("done_seen", 72'(got), 72'd1);
    check("done_latency", 72'(k), 72'(e.lat));
    check("rx_count", 72'(rx_count), 72'(e.cnt));
    check("rx_data", rx_data, e.rx);
    check("err_timeout", 72'(err_timeout), 72'(e.err));
    check("busy_at_done", 72'(busy), 72'd0);
    check("att_at_done", 72'(att), 72'h3);
    check("att_first_cycle", 72'(att_first), 72'(att_exp));
    check("other_port_att", 72'(other_low), 72'd0);
    check("psx_clk_falls", 72'(falls_seen), 72'(e.falls));
    check("cmd_bytes", cmd_obs, e.cmdv);
    @(negedge clk);
    check("done_one_cycle", 72'(done), 72'd0);
    check("rx_count_hold", 72'(rx_count), 72'(e.cnt));
    $display("txn port=%0d num_bytes=%0d lat=%0d rx_count=%0d rx_data=%0h err=%0b",
             port, nb, k, rx_count, rx_data, err_timeout);
  endtask

  initial begin : main
    int          k;
    logic [71:0] tx;

    for (int i = 0; i < 9; i++) begin
      reply[i]   = 8'hFF;
      cmd_cap[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_att", 72'(att), 72'h3);
    check("rst_psx_clk", 72'(psx_clk), 72'd1);
    check("rst_cmd", 72'(cmd), 72'd1);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_done", 72'(done), 72'd0);
    check("rst_err", 72'(err_timeout), 72'd0);
    check("rst_rx_data", rx_data, 72'd0);
    check("rst_rx_count", 72'(rx_count), 72'd0);

    // Digital pad poll on port 0, with a start pulse landing mid-frame.
    reply[0] = 8'hFF; reply[1] = PSX_ID_DIGITAL; reply[2] = PSX_PAD_MARK;
    reply[3] = 8'hFF; reply[4] = 8'hFF;
    tx = '0;
    tx[7:0]  = PSX_CMD_ADDR;
    tx[15:8] = PSX_CMD_POLL;
    run_txn(0, 5, tx, 1, 1'b1, 1'b1);

    // Port 1 with a slower ack and arbitrary bytes.
    for (int i = 0; i < 9; i++) reply[i] = 8'($urandom);
    tx = {8'($urandom), $urandom, $urandom};
    run_txn(1, 3, tx, 3, 1'b1, 1'b0);

    // Empty frame.
    run_txn(0, 0, tx, 1, 1'b1, 1'b0);

`ifdef PSX_ACK_TIMEOUT_EN
    for (int i = 0; i < 9; i++) reply[i] = 8'($urandom);
    run_txn(0, 3, tx, 1, 1'b0, 1'b0);
`endif

    // Oversized request is clamped to MAX_BYTES.
    for (int i = 0; i < 9; i++) reply[i] = 8'($urandom);
    tx = {8'($urandom), $urandom, $urandom};
    run_txn(1, 12, tx, 2, 1'b1, 1'b0);

    // Reset in the middle of the first byte.
    bc = 0; pc = 0; cur_n = 5; ack_en = 1'b1; ack_dly = 1;
    @(negedge clk);
    port_sel = 1'b0; num_bytes = 4'd5; tx_data = tx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (psx_clk && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reached_shift", 72'(psx_clk), 72'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_att", 72'(att), 72'h3);
    check("midrst_psx_clk", 72'(psx_clk), 72'd1);
    check("midrst_cmd", 72'(cmd), 72'd1);
    check("midrst_busy", 72'(busy), 72'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Normal frame after the abort.
    for (int i = 0; i < 9; i++) reply[i] = 8'($urandom);
    run_txn(1, 2, tx, 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
